div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU. Consumes register-file read data (rs1->dividend,
//  rs2->divisor) from the execute stage and produces a write-back triple (wb_addr, wb_we, result) that
//  drives the register-file write port (ad3/we3/wd3). One division in flight; execute stalls on busy.
// PARAMETERS
//  Data_width  32  operand/result width in bits (>=2)
//  Addr_width  5   destination register address width
// PORTS
//  clk       in   1            rising-edge clock
//  rst_n     in   1            synchronous active-low reset
//  start     in   1            request; accepted only when busy==0
//  op        in   2            00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start)
//  dividend  in   Data_width   rs1 value (sampled with start)
//  divisor   in   Data_width   rs2 value (sampled with start)
//  rd_addr   in   Addr_width   destination register (sampled with start)
//  flush     in   1            abort in-flight op (pipeline flush)
//  busy      out  1            state != IDLE
//  done      out  1            one-cycle pulse: result/wb_addr valid
//  wb_we     out  1            = done && (wb_addr != 0)
//  wb_addr   out  Addr_width   captured rd_addr
//  result    out  Data_width   quotient or remainder
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): state IDLE, busy=0, done=0, wb_we=0, wb_addr=0, result=0, counter=0.
//    Reset dominates start and flush; reset mid-operation discards the op, no done pulse.
//  - States: IDLE -> CALC (normal) | DONE (special case); CALC -> DONE after Data_width iterations;
//    DONE -> IDLE unconditionally. flush==1 in CALC or DONE -> IDLE next edge, no done/wb_we that cycle
//    onward (done is suppressed combinationally while flush==1). flush in IDLE: no effect.
//  - start is ignored while busy (incl. DONE cycle); no queueing. start+flush in IDLE: flush wins.
//  - Capture at accept: signed ops (DIV/REM) take |operand|, remember sign_q = sign(a)^sign(b),
//    sign_r = sign(a). Unsigned ops use raw operands.
//  - CALC: restoring shift-subtract, one quotient bit per cycle, MSB first; Data_width+1-bit partial
//    remainder; counter counts 0..Data_width-1. Final sign fix applied when entering DONE.
//  - Latency: start accepted at edge of cycle T -> normal: CALC cycles T+1..T+Data_width, done high in
//    cycle T+Data_width+1 (33 for default). Special case: done high in cycle T+1.
//  - Special cases (bypass CALC), per RISC-V spec:
//    divisor==0: DIV/DIVU result = all ones; REM/REMU result = dividend.
//    DIV/REM with dividend==MIN_NEG and divisor==-1: DIV = MIN_NEG, REM = 0.
//  - Signed rounding toward zero; remainder takes dividend's sign.
//  - result and wb_addr hold their value after done until the next accepted start; done/wb_we
//    are high for exactly one cycle per completed op.
//  - wb_we forced 0 for rd_addr==0 (x0 never written); done still pulses.
// TESTING
//  1 DIVU 100/7, rd=5 -> done at T+33, result=14, wb_addr=5, wb_we=1; REMU same operands -> 2.
//  2 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> -3; REM 7/-2 -> 1.
//  3 DIVU 0x1234/0 -> done at T+1, 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; DIV 0x80000000/-1 -> 0x80000000,
//    REM -> 0.
//  4 start pulsed at T+5 with different operands during busy -> ignored; first result unchanged,
//    exactly one done pulse.
//  5 flush at T+10 -> IDLE at T+11, busy=0, no done; new start at T+11 accepted and completes correctly.
//  6 rst_n=0 at T+20 -> next cycle all outputs 0, state IDLE, no done; DIVU 0xFFFFFFFF/1, rd=0 ->
//    result 0xFFFFFFFF, done=1, wb_we=0.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; special cases bypass the iteration and finish in one cycle.
module div_unit #(
    parameter int unsigned Data_width = 32,
    parameter int unsigned Addr_width = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [Data_width-1:0] dividend,
    input  logic [Data_width-1:0] divisor,
    input  logic [Addr_width-1:0] rd_addr,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic                  wb_we,
    output logic [Addr_width-1:0] wb_addr,
    output logic [Data_width-1:0] result
);

    localparam int unsigned CntW = $clog2(Data_width);
    localparam logic [Data_width-1:0] MinNeg = {1'b1, {(Data_width-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [Data_width-1:0] rem_q, rem_d;
    logic [Data_width-1:0] quot_q, quot_d;
    logic [Data_width-1:0] dvs_q, dvs_d;
    logic                  neg_quot_q, neg_quot_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  is_rem_q, is_rem_d;
    logic [Addr_width-1:0] wb_addr_q, wb_addr_d;
    logic [Data_width-1:0] result_q, result_d;

    logic                  op_signed, a_neg, b_neg, div_zero, ovf, q_bit;
    logic [Data_width-1:0] a_abs, b_abs, quot_next, rem_next, q_fix, r_fix;
    logic [Data_width:0]   rem_shift, diff;

    always_comb begin
        op_signed = ~op[0];
        a_neg     = op_signed & dividend[Data_width-1];
        b_neg     = op_signed & divisor[Data_width-1];
        a_abs     = a_neg ? -dividend : dividend;
        b_abs     = b_neg ? -divisor : divisor;
        div_zero  = (divisor == '0);
        ovf       = op_signed && (dividend == MinNeg) && (divisor == '1);

        // Shift next dividend bit into the partial remainder, subtract if it fits.
        rem_shift = {rem_q, quot_q[Data_width-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        q_bit     = ~diff[Data_width];
        rem_next  = q_bit ? diff[Data_width-1:0] : rem_shift[Data_width-1:0];
        quot_next = {quot_q[Data_width-2:0], q_bit};
        q_fix     = neg_quot_q ? -quot_next : quot_next;
        r_fix     = neg_rem_q ? -rem_next : rem_next;

        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        is_rem_d   = is_rem_q;
        wb_addr_d  = wb_addr_q;
        result_d   = result_q;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    wb_addr_d = rd_addr;
                    is_rem_d  = op[1];
                    cnt_d     = '0;
                    if (div_zero) begin
                        result_d = op[1] ? dividend : '1;
                        state_d  = StDone;
                    end else if (ovf) begin
                        result_d = op[1] ? '0 : MinNeg;
                        state_d  = StDone;
                    end else begin
                        rem_d      = '0;
                        quot_d     = a_abs;
                        dvs_d      = b_abs;
                        neg_quot_d = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        state_d    = StCalc;
                    end
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    rem_d  = rem_next;
                    quot_d = quot_next;
                    cnt_d  = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(Data_width - 1)) begin
                        result_d = is_rem_q ? r_fix : q_fix;
                        cnt_d    = '0;
                        state_d  = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_rem_q   <= 1'b0;
            wb_addr_q  <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvs_q      <= dvs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            is_rem_q   <= is_rem_d;
            wb_addr_q  <= wb_addr_d;
            result_q   <= result_d;
        end
    end

    // A flush arriving in the DONE cycle must kill the write-back immediately.
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone) && !flush;
    assign wb_we   = done && (wb_addr_q != '0);
    assign wb_addr = wb_addr_q;
    assign result  = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected write-backs, a monitor checks each done.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [4:0]  rd_addr = '0;
    logic        flush = 1'b0;
    logic        busy, done, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  addr;
        logic        we;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

    div_unit #(.Data_width(32), .Addr_width(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .rd_addr  (rd_addr),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .result   (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a start for one cycle; optionally push the expected write-back first.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic push, input logic [31:0] res,
                         input logic special);
        exp_t e;
        if (push) begin
            e.res  = res;
            e.addr = rd;
            e.we   = (rd != 5'd0);
            e.cyc  = cyc + (special ? 1 : 33);
            sb_q.push_back(e);
        end
        op = o; dividend = a; divisor = b; rd_addr = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {27'd0, wb_addr}, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
                chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                chk("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Unsigned and signed basics
        issue(OpDivu, 32'd100, 32'd7, 5'd5, 1'b1, 32'd14, 1'b0);         wait_idle();
        issue(OpRemu, 32'd100, 32'd7, 5'd6, 1'b1, 32'd2, 1'b0);          wait_idle();
        issue(OpDiv, -32'sd7, 32'd2, 5'd7, 1'b1, 32'hFFFF_FFFD, 1'b0);   wait_idle();
        issue(OpRem, -32'sd7, 32'd2, 5'd8, 1'b1, 32'hFFFF_FFFF, 1'b0);   wait_idle();
        issue(OpDiv, 32'd7, -32'sd2, 5'd9, 1'b1, 32'hFFFF_FFFD, 1'b0);   wait_idle();
        issue(OpRem, 32'd7, -32'sd2, 5'd10, 1'b1, 32'd1, 1'b0);          wait_idle();

        // Special cases: divide by zero and signed overflow
        issue(OpDivu, 32'h1234, 32'd0, 5'd11, 1'b1, 32'hFFFF_FFFF, 1'b1); wait_idle();
        issue(OpRem, 32'h1234, 32'd0, 5'd12, 1'b1, 32'h1234, 1'b1);       wait_idle();
        issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, 32'h8000_0000, 1'b1);
        wait_idle();
        issue(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 32'd0, 1'b1);
        wait_idle();

        // start while busy is ignored
        issue(OpDivu, 32'd1000, 32'd10, 5'd3, 1'b1, 32'd100, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_mid_calc", {31'd0, busy}, 32'd1);
        op = OpDivu; dividend = 32'd5; divisor = 32'd1; rd_addr = 5'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();

        // flush aborts; next start right after is accepted
        issue(OpDiv, 32'd12345, -32'sd5, 5'd9, 1'b0, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        issue(OpDiv, 32'd100, -32'sd7, 5'd9, 1'b1, 32'hFFFF_FFF2, 1'b0);  wait_idle();

        // reset mid-operation, then write to x0
        issue(OpRemu, 32'd50, 32'd3, 5'd4, 1'b0, 32'd0, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("mid_rst_wb_addr", {27'd0, wb_addr}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        issue(OpDivu, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
